// File: rtl/spart_if.sv
// Processor-side control and serial-line signals of the SPART.
// The tristate databus stays a plain port on the SPART itself.
interface spart_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;
  logic       txd;
  logic       rxd;

  modport master (output iocs, iorw, ioaddr, rxd, input rda, tbr, txd);
  modport slave  (input iocs, iorw, ioaddr, rxd, output rda, tbr, txd);
endinterface

// File: rtl/spart.sv
// Special-purpose UART: 8N1 transmitter and receiver, 16x oversampled, programmable divisor.
// Optional build macro SPART_RX_OVERRUN_EN enables the status overrun flag (bit 2).
module spart #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  spart_if.slave     bus,
  inout  wire  [7:0] databus
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam logic [1:0] A_RX  = 2'b00;
  localparam logic [1:0] A_TX  = 2'b01;
  localparam logic [1:0] A_DBL = 2'b10;
  localparam logic [1:0] A_DBH = 2'b11;

  // ---------------- bus decode ----------------
  logic rd_en, wr_en, wr_tx, wr_dbl, wr_dbh, rd_rx, rd_st;
  assign rd_en  = rst & bus.iocs & bus.iorw;
  assign wr_en  = bus.iocs & ~bus.iorw;
  assign wr_tx  = wr_en && (bus.ioaddr == A_TX);
  assign wr_dbl = wr_en && (bus.ioaddr == A_DBL);
  assign wr_dbh = wr_en && (bus.ioaddr == A_DBH);
  assign rd_rx  = rd_en && (bus.ioaddr == A_RX);
  assign rd_st  = rd_en && (bus.ioaddr == A_TX);

  // ---------------- baud generator ----------------
  logic [15:0] divisor_q, divisor_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic        reload_q, reload_d;
  logic        baud_en;

  // The reload cycle itself never pulses, so a new divisor starts a clean period.
  assign baud_en = (baud_cnt_q == 16'd0) && !reload_q;

  always_comb begin
    divisor_d = divisor_q;
    if (wr_dbl) divisor_d[7:0]  = databus;
    if (wr_dbh) divisor_d[15:8] = databus;
    reload_d = wr_dbh;
    if (reload_q || baud_cnt_q == 16'd0) baud_cnt_d = divisor_q;
    else                                 baud_cnt_d = baud_cnt_q - 16'd1;
  end

  // ---------------- rxd synchroniser ----------------
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_prev_q, rx_prev_d;
  logic                   rxs;

  assign rxs       = sync_q[SYNC_STAGES-1];
  assign sync_d    = {sync_q[SYNC_STAGES-2:0], bus.rxd};
  assign rx_prev_d = rxs;

  // ---------------- transmitter ----------------
  state_e     tx_state_q;
  logic [7:0] tx_sh_q;
  logic [3:0] tx_tick_q;
  logic [2:0] tx_bit_q;
  logic       txd_q, tbr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= IDLE;
      tx_sh_q    <= 8'h00;
      tx_tick_q  <= 4'd0;
      tx_bit_q   <= 3'd0;
      txd_q      <= 1'b1;
      tbr_q      <= 1'b1;
    end else begin
      case (tx_state_q)
        IDLE: begin
          if (tbr_q) begin
            if (wr_tx) begin
              tx_sh_q <= databus;
              tbr_q   <= 1'b0;
            end
          end else if (baud_en) begin
            tx_state_q <= START;
            txd_q      <= 1'b0;
            tx_tick_q  <= 4'd0;
          end
        end
        START: if (baud_en) begin
          tx_tick_q <= tx_tick_q + 4'd1;
          if (tx_tick_q == 4'd15) begin
            tx_state_q <= DATA;
            txd_q      <= tx_sh_q[0];
            tx_bit_q   <= 3'd0;
          end
        end
        DATA: if (baud_en) begin
          tx_tick_q <= tx_tick_q + 4'd1;
          if (tx_tick_q == 4'd15) begin
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= STOP;
              txd_q      <= 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q + 3'd1;
              txd_q    <= tx_sh_q[1];
              tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
            end
          end
        end
        STOP: if (baud_en) begin
          tx_tick_q <= tx_tick_q + 4'd1;
          if (tx_tick_q == 4'd15) begin
            tx_state_q <= IDLE;
            tbr_q      <= 1'b1;
          end
        end
        default: tx_state_q <= IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  state_e     rx_state_q;
  logic [7:0] rx_sh_q;
  logic [3:0] rx_tick_q;
  logic [2:0] rx_bit_q;
  logic       rx_done;

  // Valid stop sample: the byte is committed on this edge.
  assign rx_done = (rx_state_q == STOP) && baud_en && (rx_tick_q == 4'd7) && rxs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_q <= IDLE;
      rx_sh_q    <= 8'h00;
      rx_tick_q  <= 4'd0;
      rx_bit_q   <= 3'd0;
    end else begin
      case (rx_state_q)
        IDLE: if (rx_prev_q && !rxs) begin
          rx_state_q <= START;
          rx_tick_q  <= 4'd0;
        end
        START: if (baud_en) begin
          rx_tick_q <= rx_tick_q + 4'd1;
          if (rx_tick_q == 4'd7 && rxs) begin
            rx_state_q <= IDLE;
          end else if (rx_tick_q == 4'd15) begin
            rx_state_q <= DATA;
            rx_bit_q   <= 3'd0;
          end
        end
        DATA: if (baud_en) begin
          rx_tick_q <= rx_tick_q + 4'd1;
          if (rx_tick_q == 4'd7) rx_sh_q <= {rxs, rx_sh_q[7:1]};
          if (rx_tick_q == 4'd15) begin
            if (rx_bit_q == 3'd7) rx_state_q <= STOP;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end
        end
        // Leave at mid-stop so a back-to-back start edge is not missed.
        STOP: if (baud_en) begin
          rx_tick_q <= rx_tick_q + 4'd1;
          if (rx_tick_q == 4'd7) rx_state_q <= IDLE;
        end
        default: rx_state_q <= IDLE;
      endcase
    end
  end

  // ---------------- receive buffer / status ----------------
  logic [7:0] rbuf_q, rbuf_d;
  logic       rda_q, rda_d;
  logic       ovr;

  always_comb begin
    rbuf_d = rx_done ? rx_sh_q : rbuf_q;
    rda_d  = rda_q;
    if (rx_done)    rda_d = 1'b1;
    else if (rd_rx) rda_d = 1'b0;
  end

`ifdef SPART_RX_OVERRUN_EN
  logic ovr_q, ovr_d;
  always_comb begin
    ovr_d = ovr_q;
    if (rx_done && rda_q) ovr_d = 1'b1;
    else if (rd_st)       ovr_d = 1'b0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovr_q <= 1'b0;
    else      ovr_q <= ovr_d;
  end
  assign ovr = ovr_q;
`else
  assign ovr = 1'b0;
`endif

  // ---------------- shared flops ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divisor_q  <= 16'h0145;
      baud_cnt_q <= 16'h0145;
      reload_q   <= 1'b0;
      sync_q     <= '1;
      rx_prev_q  <= 1'b1;
      rbuf_q     <= 8'h00;
      rda_q      <= 1'b0;
    end else begin
      divisor_q  <= divisor_d;
      baud_cnt_q <= baud_cnt_d;
      reload_q   <= reload_d;
      sync_q     <= sync_d;
      rx_prev_q  <= rx_prev_d;
      rbuf_q     <= rbuf_d;
      rda_q      <= rda_d;
    end
  end

  // ---------------- outputs ----------------
  logic [7:0] rd_data;
  always_comb begin
    rd_data = 8'h00;
    case (bus.ioaddr)
      A_RX:    rd_data = rbuf_q;
      A_TX:    rd_data = {5'b0, ovr, tbr_q, rda_q};
      default: rd_data = 8'h00;
    endcase
  end

  assign databus = rd_en ? rd_data : 8'bz;
  assign bus.rda = rda_q;
  assign bus.tbr = tbr_q;
  assign bus.txd = txd_q;

endmodule

// File: tb/tb_spart.sv
// Directed bench for spart: baud timing, TX framing/drop, RX receive/glitch/framing, overrun, async reset.
module tb_spart;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] drv;
  logic       drv_oe;
  wire  [7:0] databus;
  int         checks = 0;
  int         errors = 0;

  spart_if bus();
  assign databus = drv_oe ? drv : 8'bz;

  spart #(.SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .databus (databus)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, actual running, required done");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = a; drv = d; drv_oe = 1'b1;
    @(negedge clk);
    bus.iocs = 1'b0; drv_oe = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = a;
    #1 d = databus;
    @(negedge clk);
    bus.iocs = 1'b0; bus.iorw = 1'b0;
  endtask

  // Clocks from one baud enable to the next, sampled on negedges.
  task automatic measure_period(output int p);
    int n = 0;
    while (!dut.baud_en && n < 2000) begin @(negedge clk); n++; end
    @(negedge clk);
    p = 1;
    while (!dut.baud_en && p < 2000) begin @(negedge clk); p++; end
  endtask

  // 80 clocks per bit with divisor 4.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); bus.rxd = f[i];
      repeat (79) @(negedge clk);
    end
    @(negedge clk); bus.rxd = 1'b1;
  endtask

  task automatic test_reset;
    int p; logic [7:0] d;
    rst = 1'b0; bus.iocs = 1'b0; bus.iorw = 1'b0; bus.ioaddr = 2'b00;
    bus.rxd = 1'b1; drv = 8'h00; drv_oe = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.rda !== 1'b0) begin errors++; $display("FAIL reset_rda actual %b required 0", bus.rda); end
    checks++; if (bus.tbr !== 1'b1) begin errors++; $display("FAIL reset_tbr actual %b required 1", bus.tbr); end
    checks++; if (bus.txd !== 1'b1) begin errors++; $display("FAIL reset_txd actual %b required 1", bus.txd); end
    rst = 1'b1;
    measure_period(p);
    checks++; if (p != 326) begin errors++; $display("FAIL reset_period actual %0d required 326", p); end
    bus_read(2'b01, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL reset_status actual %h required 02", d); end
    bus_read(2'b00, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_rbuf actual %h required 00", d); end
  endtask

  task automatic test_baud;
    int p;
    bus_write(2'b10, 8'h50);
    bus_write(2'b11, 8'h00);
    measure_period(p);
    checks++; if (p != 81) begin errors++; $display("FAIL baud_period actual %0d required 81", p); end
  endtask

  task automatic test_tx_and_drop;
    logic [9:0] exp;
    int n, lows, idx;
    exp = {1'b1, 8'hA5, 1'b0};
    bus_write(2'b01, 8'hA5);
    checks++; if (bus.tbr !== 1'b0) begin errors++; $display("FAIL tx_tbr_low actual %b required 0", bus.tbr); end
    n = 0;
    while (bus.txd !== 1'b0 && n < 300) begin @(negedge clk); n++; end
    checks++; if (n >= 300) begin errors++; $display("FAIL tx_start_seen actual timeout required start bit"); end
    idx = 0;
    for (int c = 1; c <= 648 + 9*1296; c++) begin
      @(negedge clk);
      if (c == 3000) begin
        bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = 2'b01; drv = 8'h3C; drv_oe = 1'b1;
      end
      if (c == 3001) begin bus.iocs = 1'b0; drv_oe = 1'b0; end
      if (c == 648 + idx*1296) begin
        checks++;
        if (bus.txd !== exp[idx]) begin
          errors++; $display("FAIL tx_bit%0d actual %b required %b", idx, bus.txd, exp[idx]);
        end
        idx++;
      end
    end
    n = 0;
    while (bus.tbr !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    checks++; if (bus.tbr !== 1'b1) begin errors++; $display("FAIL tx_tbr_high actual %b required 1", bus.tbr); end
    checks++; if (n < 500) begin errors++; $display("FAIL tx_tbr_timing actual %0d required >=500", n); end
    lows = 0;
    repeat (2*1296) begin @(negedge clk); if (bus.txd !== 1'b1) lows++; end
    checks++; if (lows != 0) begin errors++; $display("FAIL tx_no_dropped_frame actual %0d required 0", lows); end
  endtask

  task automatic test_rx;
    logic [7:0] d;
    bus_write(2'b10, 8'h04);
    bus_write(2'b11, 8'h00);
    send_frame(8'hC3, 1'b1);
    repeat (10) @(negedge clk);
    checks++; if (bus.rda !== 1'b1) begin errors++; $display("FAIL rx_rda_set actual %b required 1", bus.rda); end
    bus_read(2'b00, d);
    checks++; if (d !== 8'hC3) begin errors++; $display("FAIL rx_data actual %h required c3", d); end
    checks++; if (bus.rda !== 1'b0) begin errors++; $display("FAIL rx_rda_clear actual %b required 0", bus.rda); end
    bus_read(2'b01, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL rx_status_idle actual %h required 02", d); end
  endtask

  task automatic test_rx_errors;
    logic [7:0] d;
    @(negedge clk); bus.rxd = 1'b0;
    @(negedge clk); bus.rxd = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (bus.rda !== 1'b0) begin errors++; $display("FAIL rx_glitch actual %b required 0", bus.rda); end
    send_frame(8'h55, 1'b0);
    repeat (100) @(negedge clk);
    checks++; if (bus.rda !== 1'b0) begin errors++; $display("FAIL rx_framing_rda actual %b required 0", bus.rda); end
    bus_read(2'b00, d);
    checks++; if (d !== 8'hC3) begin errors++; $display("FAIL rx_framing_buf actual %h required c3", d); end
  endtask

  task automatic test_overrun;
    logic [7:0] d, exp_st;
`ifdef SPART_RX_OVERRUN_EN
    exp_st = 8'h07;
`else
    exp_st = 8'h03;
`endif
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (10) @(negedge clk);
    bus_read(2'b01, d);
    checks++; if (d !== exp_st) begin errors++; $display("FAIL ovr_status actual %h required %h", d, exp_st); end
    bus_read(2'b00, d);
    checks++; if (d !== 8'h22) begin errors++; $display("FAIL ovr_data actual %h required 22", d); end
    bus_read(2'b01, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL ovr_cleared actual %h required 02", d); end
  endtask

  task automatic test_reset_mid_tx;
    int n, p; logic [7:0] d;
    bus_write(2'b01, 8'h00);
    n = 0;
    while (bus.txd !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    repeat (200) @(negedge clk);
    checks++; if (bus.txd !== 1'b0) begin errors++; $display("FAIL midtx_busy actual %b required 0", bus.txd); end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.txd !== 1'b1) begin errors++; $display("FAIL midtx_txd actual %b required 1", bus.txd); end
    checks++; if (bus.tbr !== 1'b1) begin errors++; $display("FAIL midtx_tbr actual %b required 1", bus.tbr); end
    @(negedge clk); rst = 1'b1;
    measure_period(p);
    checks++; if (p != 326) begin errors++; $display("FAIL midtx_period actual %0d required 326", p); end
    bus_read(2'b01, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL midtx_status actual %h required 02", d); end
  endtask

  initial begin
    test_reset;
    test_baud;
    test_tx_and_drop;
    test_rx;
    test_rx_errors;
    test_overrun;
    test_reset_mid_tx;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
